wave_profile_gen: RTL and testbench
===================================

Name: wave_profile_gen

Overview:
- Upstream producer for the display stage's `wave_prof` / `wave_index` / `wave_we` write port.
- Once per frame, triggered by the falling edge of `vsync`, streams NUM_SAMPLES sine-wave profile heights into display's shadow buffer, one sample per `vclock`.
- Heights are computed as CENTER − (amplitude · sin(phase)) >> 7, clamped to the screen. Phase comes from a per-frame base and step.
- The scrolling/game logic above drives `phase_base`, `freq_step` and `amplitude`.

Parameters:
- NUM_SAMPLES, 1024, samples written per frame (one per screen column).
- CENTER, 384, profile height for zero sine value.
- MAX_Y, 767, upper clamp for `wave_prof`.
- PHASE_W, 16, phase accumulator width.

Ports:
- vclock  in  1  65 MHz pixel clock; all logic on posedge.
- reset  in  1  synchronous, active-low (0 = reset).
- vsync  in  1  active-low vertical sync from xvga; sampled on vclock.
- phase_base  in  16  starting phase of column 0; latched at frame start.
- freq_step  in  16  phase increment per column; latched at frame start.
- amplitude  in  9  unsigned wave amplitude, 0..511; latched at frame start.
- wave_prof  out  10  profile height for `wave_index`.
- wave_index  out  11  column being written, 0..NUM_SAMPLES−1.
- wave_we  out  1  write strobe, one sample per high cycle.
- busy  out  1  high from frame start until the last write.
- overrun  out  1  one-cycle pulse when a frame start arrives while busy.

Behaviour:
- Reset (`reset` = 0 at a posedge): `wave_prof` = 0, `wave_index` = 0, `wave_we` = 0, `busy` = 0, `overrun` = 0.
  - FSM goes to IDLE, the pipeline valids clear, and `vsync_d` is set to 1.
  - Reset asserted mid-stream aborts immediately; no further `wave_we` is issued.
- Frame start: `vsync_d` = 1 and `vsync` = 0 at a posedge (one registered delay).
- FSM states:
  - IDLE: on frame start, latch `phase_base`, `freq_step` and `amplitude`; set sample counter n = 0; `busy` <= 1; go to RUN.
  - RUN: each cycle issue phase p(n) = `phase_base` + n·`freq_step` mod 2^16, computed by accumulation, not multiply. Increment n. After issuing n = NUM_SAMPLES−1, go to DRAIN.
  - DRAIN: wait until the pipeline is empty. `busy` <= 0 in the cycle the last `wave_we` is high. Go to IDLE.
- Pipeline, 3 stages; `wave_we` goes high exactly 3 cycles after a phase is issued:
  - S1, sine LUT registered lookup.
    - quadrant q = p[15:14], address a = p[13:8].
    - q = 1 or 3 uses the mirrored address 63 − a.
    - q = 2 or 3 negates the result.
    - Output is signed 8-bit, range −127..127.
  - S2: product = amplitude × sine, signed 17 bits, registered.
  - S3: y = CENTER − (product >>> 7), arithmetic shift (floor).
    - Clamp: y < 0 gives 0; y > MAX_Y gives MAX_Y.
    - Register `wave_prof` and `wave_index` = n (index delayed alongside the phase); `wave_we` = 1.
- First write occurs 5 cycles after the falling `vsync` edge. Exactly NUM_SAMPLES writes occur on consecutive cycles, indices strictly 0..NUM_SAMPLES−1 in order.
- `wave_we` is 0 whenever no valid sample is at S3.
- Frame start while `busy`: ignored, the current stream continues, and `overrun` pulses for 1 cycle.
- Input changes mid-stream have no effect; only the latched copies are used.
- amplitude = 0: every sample equals CENTER.
- LUT entry k = round(127 · sin(π/2 · (k + 0.5)/64)), k = 0..63. This gives entry 0 = 2 and entry 63 = 127.

Decomposition:
- Shared package `wave_pkg`:
  - constants CENTER, MAX_Y, NUM_SAMPLES, PHASE_W
  - FSM state enum {IDLE, RUN, DRAIN}
- One sub-module, `sine_quarter_lut`:
  - 64×7-bit ROM with 1-cycle registered output.
  - Quadrant mirroring and sign handled inside.
  - Input 8-bit phase, output signed 8-bit.

Test Plan:
- Frame start with amplitude = 0 → 1024 consecutive writes, index 0..1023, all `wave_prof` = 384. First `wave_we` occurs 5 cycles after the `vsync` fall; `busy` is low the cycle after the last write.
- amplitude = 128, phase_base = 0, freq_step = 0x4000 → profile repeats with period 4: 382, 257, 386, 511, 382, …
- amplitude = 511, same phases → index 1 = 0 (clamped low, from −123), index 3 = 767 (clamped high, from 892).
- Second `vsync` fall at write index 500 → `overrun` pulses once. The stream completes 1024 writes uninterrupted, and no restart occurs.
- `reset` = 0 at write index 200 → `wave_we` is 0 from the next cycle and all outputs are 0. After release, the next `vsync` fall produces a full clean 1024-sample stream from index 0.
- phase_base = 0xFFFF, freq_step = 1 → index 0 phase 0xFFFF, giving sample 386. Index 1 wraps to phase 0, giving sample 382.

Source files
------------

// File: rtl/wave_pkg.sv
// Shared constants and FSM encoding for the wave profile generator.
package wave_pkg;

    localparam int NUM_SAMPLES = 1024;
    localparam int CENTER      = 384;
    localparam int MAX_Y       = 767;
    localparam int PHASE_W     = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

endpackage

// File: rtl/sine_quarter_lut.sv
// Full-wave sine from a 64-entry quarter-wave ROM, signed 8-bit output (-127..127).
// Latency 1 cycle (registered output); no flow control.
module sine_quarter_lut (
    input  logic       vclock,
    input  logic [7:0] i_phase,
    output logic [7:0] o_sine
);

    logic [5:0] w_addr;
    logic [6:0] w_mag;
    logic [7:0] w_pos;
    logic [7:0] r_sine;

    // Odd quadrants run the quarter wave backwards; 63 - a is the bitwise inverse.
    assign w_addr = i_phase[6] ? ~i_phase[5:0] : i_phase[5:0];

    // Entry k = round(127 * sin(pi/2 * (k + 0.5) / 64)).
    always_comb begin
        w_mag = 7'd0;
        case (w_addr)
            6'd0:  w_mag = 7'd2;   6'd1:  w_mag = 7'd5;   6'd2:  w_mag = 7'd8;   6'd3:  w_mag = 7'd11;
            6'd4:  w_mag = 7'd14;  6'd5:  w_mag = 7'd17;  6'd6:  w_mag = 7'd20;  6'd7:  w_mag = 7'd23;
            6'd8:  w_mag = 7'd26;  6'd9:  w_mag = 7'd29;  6'd10: w_mag = 7'd32;  6'd11: w_mag = 7'd35;
            6'd12: w_mag = 7'd38;  6'd13: w_mag = 7'd41;  6'd14: w_mag = 7'd44;  6'd15: w_mag = 7'd47;
            6'd16: w_mag = 7'd50;  6'd17: w_mag = 7'd53;  6'd18: w_mag = 7'd56;  6'd19: w_mag = 7'd58;
            6'd20: w_mag = 7'd61;  6'd21: w_mag = 7'd64;  6'd22: w_mag = 7'd67;  6'd23: w_mag = 7'd69;
            6'd24: w_mag = 7'd72;  6'd25: w_mag = 7'd74;  6'd26: w_mag = 7'd77;  6'd27: w_mag = 7'd79;
            6'd28: w_mag = 7'd82;  6'd29: w_mag = 7'd84;  6'd30: w_mag = 7'd86;  6'd31: w_mag = 7'd89;
            6'd32: w_mag = 7'd91;  6'd33: w_mag = 7'd93;  6'd34: w_mag = 7'd95;  6'd35: w_mag = 7'd97;
            6'd36: w_mag = 7'd99;  6'd37: w_mag = 7'd101; 6'd38: w_mag = 7'd103; 6'd39: w_mag = 7'd105;
            6'd40: w_mag = 7'd106; 6'd41: w_mag = 7'd108; 6'd42: w_mag = 7'd110; 6'd43: w_mag = 7'd111;
            6'd44: w_mag = 7'd113; 6'd45: w_mag = 7'd114; 6'd46: w_mag = 7'd115; 6'd47: w_mag = 7'd117;
            6'd48: w_mag = 7'd118; 6'd49: w_mag = 7'd119; 6'd50: w_mag = 7'd120; 6'd51: w_mag = 7'd121;
            6'd52: w_mag = 7'd122; 6'd53: w_mag = 7'd123; 6'd54: w_mag = 7'd124; 6'd55: w_mag = 7'd124;
            6'd56: w_mag = 7'd125; 6'd57: w_mag = 7'd125; 6'd58: w_mag = 7'd126; 6'd59: w_mag = 7'd126;
            6'd60: w_mag = 7'd127; 6'd61: w_mag = 7'd127; 6'd62: w_mag = 7'd127; 6'd63: w_mag = 7'd127;
            default: w_mag = 7'd0;
        endcase
    end

    assign w_pos = {1'b0, w_mag};

    // Lower half of the cycle is the negated upper half.
    always_ff @(posedge vclock) begin
        r_sine <= i_phase[7] ? (~w_pos + 8'd1) : w_pos;
    end

    assign o_sine = r_sine;

endmodule

// File: rtl/wave_profile_gen.sv
// Streams NUM_SAMPLES sine profile heights into the display shadow buffer once per frame.
// First write 5 cycles after the vsync fall, then one per cycle; no backpressure, late frame starts flag overrun.
module wave_profile_gen
    import wave_pkg::*;
(
    input  logic        vclock,
    input  logic        reset,
    input  logic        vsync,
    input  logic [15:0] phase_base,
    input  logic [15:0] freq_step,
    input  logic [8:0]  amplitude,
    output logic [9:0]  wave_prof,
    output logic [10:0] wave_index,
    output logic        wave_we,
    output logic        busy,
    output logic        overrun
);

    localparam logic signed [16:0] C_CENTER = 17'(CENTER);
    localparam logic signed [16:0] C_MAX_Y  = 17'(MAX_Y);

    state_t               r_state, w_state_nxt;
    logic                 r_vsync_d;
    logic                 w_frame_start, w_start, w_issue, w_busy_clr;
    logic                 w_last_issue, w_drain_done;
    logic [PHASE_W-1:0]   r_acc, r_step;
    logic [8:0]           r_amp;
    logic [10:0]          r_n;
    logic [7:0]           r_phase;
    logic [10:0]          r_p_idx, r_s1_idx, r_s2_idx, r_idx;
    logic                 r_p_vld, r_s1_vld, r_s2_vld, r_we;
    logic [7:0]           w_sine;
    logic signed [16:0]   w_amp_x, w_sine_x, w_prod, r_prod, w_shift, w_y;
    logic [9:0]           w_prof_clamped, r_prof;
    logic                 r_busy, r_overrun;

    assign w_frame_start = r_vsync_d & ~vsync;
    assign w_last_issue  = (r_n == 11'(NUM_SAMPLES - 1));
    assign w_drain_done  = r_we & ~r_s2_vld & ~r_s1_vld & ~r_p_vld;

    always_ff @(posedge vclock) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_issue     = 1'b0;
        w_busy_clr  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_frame_start) begin
                    w_start     = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_issue = 1'b1;
                if (w_last_issue) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_drain_done) begin
                    w_busy_clr  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    sine_quarter_lut u_lut (
        .vclock  (vclock),
        .i_phase (r_phase),
        .o_sine  (w_sine)
    );

    assign w_amp_x  = $signed({8'd0, r_amp});
    assign w_sine_x = $signed({{9{w_sine[7]}}, w_sine});
    assign w_prod   = w_amp_x * w_sine_x;

    // Arithmetic shift floors negative products, so the profile is not symmetric about CENTER.
    assign w_shift = r_prod >>> 7;
    assign w_y     = C_CENTER - w_shift;

    always_comb begin
        w_prof_clamped = w_y[9:0];
        if (w_y[16]) begin
            w_prof_clamped = 10'd0;
        end else if (w_y > C_MAX_Y) begin
            w_prof_clamped = C_MAX_Y[9:0];
        end
    end

    always_ff @(posedge vclock) begin
        if (!reset) begin
            r_vsync_d <= 1'b1;
            r_acc     <= '0;
            r_step    <= '0;
            r_amp     <= '0;
            r_n       <= '0;
            r_phase   <= '0;
            r_p_idx   <= '0;
            r_s1_idx  <= '0;
            r_s2_idx  <= '0;
            r_idx     <= '0;
            r_p_vld   <= 1'b0;
            r_s1_vld  <= 1'b0;
            r_s2_vld  <= 1'b0;
            r_we      <= 1'b0;
            r_prod    <= '0;
            r_prof    <= '0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_vsync_d <= vsync;
            r_overrun <= w_frame_start & r_busy;

            if (w_start) begin
                r_acc  <= phase_base;
                r_step <= freq_step;
                r_amp  <= amplitude;
                r_n    <= '0;
                r_busy <= 1'b1;
            end else if (w_busy_clr) begin
                r_busy <= 1'b0;
            end

            // Phase accumulates per column; only the top byte feeds the LUT.
            r_p_vld <= w_issue;
            if (w_issue) begin
                r_phase <= r_acc[PHASE_W-1 -: 8];
                r_p_idx <= r_n;
                r_acc   <= r_acc + r_step;
                r_n     <= r_n + 11'd1;
            end

            r_s1_vld <= r_p_vld;
            r_s1_idx <= r_p_idx;
            r_s2_vld <= r_s1_vld;
            r_s2_idx <= r_s1_idx;
            r_prod   <= w_prod;
            r_we     <= r_s2_vld;
            if (r_s2_vld) begin
                r_prof <= w_prof_clamped;
                r_idx  <= r_s2_idx;
            end
        end
    end

    assign wave_prof  = r_prof;
    assign wave_index = r_idx;
    assign wave_we    = r_we;
    assign busy       = r_busy;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_wave_profile_gen.sv
// Directed vectors and corner-case sequences for wave_profile_gen.
module tb_wave_profile_gen;

    logic        vclock = 1'b0;
    logic        reset = 1'b0;
    logic        vsync = 1'b1;
    logic [15:0] phase_base = '0;
    logic [15:0] freq_step = '0;
    logic [8:0]  amplitude = '0;
    logic [9:0]  wave_prof;
    logic [10:0] wave_index;
    logic        wave_we;
    logic        busy;
    logic        overrun;

    wave_profile_gen dut (
        .vclock     (vclock),
        .reset      (reset),
        .vsync      (vsync),
        .phase_base (phase_base),
        .freq_step  (freq_step),
        .amplitude  (amplitude),
        .wave_prof  (wave_prof),
        .wave_index (wave_index),
        .wave_we    (wave_we),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 vclock = ~vclock;

    typedef struct {
        logic [15:0] base;
        logic [15:0] step;
        logic [8:0]  amp;
        int          idx;
        int          exp;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    int ord_bad = 0;
    int ovr_cnt = 0;
    int base_cnt = 0;
    int ord0 = 0;
    int cap [1024];
    vec_t vt [24];

    // Write monitor: captures each sample by its position in the current frame.
    always @(negedge vclock) begin
        if (wave_we) begin
            if (wr_cnt - base_cnt < 1024) cap[wr_cnt - base_cnt] = int'(wave_prof);
            if (int'(wave_index) != wr_cnt - base_cnt) ord_bad++;
            wr_cnt++;
        end
        if (overrun) ovr_cnt++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic start_frame(input logic [15:0] b, input logic [15:0] s, input logic [8:0] a);
        int first;
        first = -1;
        @(negedge vclock);
        phase_base = b;
        freq_step  = s;
        amplitude  = a;
        base_cnt   = wr_cnt;
        ord0       = ord_bad;
        vsync      = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge vclock);
            if (c == 1) vsync = 1'b1;
            if (wave_we && first < 0) first = c;
        end
        chk("first_we_latency", first, 5);
        chk("busy_running", int'(busy), 1);
    endtask

    task automatic wait_idx(input int k);
        int t;
        t = 0;
        while (!(wave_we && int'(wave_index) == k) && t < 1300) begin
            @(negedge vclock);
            t++;
        end
        chk("reach_index", int'(t < 1300), 1);
    endtask

    task automatic wait_end(input string tag);
        wait_idx(1023);
        chk({tag, "_busy_last"}, int'(busy), 1);
        @(negedge vclock);
        chk({tag, "_busy_after"}, int'(busy), 0);
        chk({tag, "_we_after"}, int'(wave_we), 0);
        chk({tag, "_count"}, wr_cnt - base_cnt, 1024);
        chk({tag, "_order"}, ord_bad - ord0, 0);
    endtask

    initial begin
        int bad;
        int ov0;

        vt[0]  = '{16'h0000, 16'h4000, 9'd128, 0,    382};
        vt[1]  = '{16'h0000, 16'h4000, 9'd128, 1,    257};
        vt[2]  = '{16'h0000, 16'h4000, 9'd128, 2,    386};
        vt[3]  = '{16'h0000, 16'h4000, 9'd128, 3,    511};
        vt[4]  = '{16'h0000, 16'h4000, 9'd128, 4,    382};
        vt[5]  = '{16'h0000, 16'h4000, 9'd128, 1023, 511};
        vt[6]  = '{16'h0000, 16'h4000, 9'd511, 0,    377};
        vt[7]  = '{16'h0000, 16'h4000, 9'd511, 1,    0};
        vt[8]  = '{16'h0000, 16'h4000, 9'd511, 2,    392};
        vt[9]  = '{16'h0000, 16'h4000, 9'd511, 3,    767};
        vt[10] = '{16'hFFFF, 16'h0001, 9'd128, 0,    386};
        vt[11] = '{16'hFFFF, 16'h0001, 9'd128, 1,    382};
        vt[12] = '{16'hFFFF, 16'h0001, 9'd128, 2,    382};
        vt[13] = '{16'h0000, 16'h0100, 9'd128, 1,    379};
        vt[14] = '{16'h0000, 16'h0100, 9'd128, 21,   320};
        vt[15] = '{16'h0000, 16'h0100, 9'd128, 31,   295};
        vt[16] = '{16'h0000, 16'h0100, 9'd128, 42,   274};
        vt[17] = '{16'h0000, 16'h0100, 9'd128, 64,   257};
        vt[18] = '{16'h0000, 16'h0100, 9'd128, 127,  382};
        vt[19] = '{16'h0000, 16'h0100, 9'd128, 130,  392};
        vt[20] = '{16'h0000, 16'h0100, 9'd128, 255,  386};
        vt[21] = '{16'h2A00, 16'h0000, 9'd300, 0,    127};
        vt[22] = '{16'h2A00, 16'h0000, 9'd300, 1023, 127};
        vt[23] = '{16'hAA00, 16'h0000, 9'd300, 500,  642};

        // Reset values
        repeat (3) @(negedge vclock);
        chk("rst_prof", int'(wave_prof), 0);
        chk("rst_index", int'(wave_index), 0);
        chk("rst_we", int'(wave_we), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun), 0);
        reset = 1'b1;
        repeat (2) @(negedge vclock);

        // Zero amplitude: flat profile at CENTER
        start_frame(16'h1234, 16'h0777, 9'd0);
        wait_end("amp0");
        bad = 0;
        for (int i = 0; i < 1024; i++) if (cap[i] != 384) bad++;
        chk("amp0_all_center", bad, 0);

        // Table of single-sample expectations; a new frame runs when the setup changes
        for (int i = 0; i < 24; i++) begin
            if (i == 0 || vt[i].base != vt[i-1].base || vt[i].step != vt[i-1].step ||
                vt[i].amp != vt[i-1].amp) begin
                start_frame(vt[i].base, vt[i].step, vt[i].amp);
                wait_end($sformatf("frame_v%0d", i));
            end
            chk($sformatf("vec%0d_idx%0d", i, vt[i].idx), cap[vt[i].idx], vt[i].exp);
        end

        // Frame start while busy, with inputs changed mid-stream
        ov0 = ovr_cnt;
        start_frame(16'h0000, 16'h4000, 9'd128);
        phase_base = 16'h1357;
        freq_step  = 16'h0101;
        amplitude  = 9'd511;
        wait_idx(500);
        vsync = 1'b0;
        @(negedge vclock);
        vsync = 1'b1;
        wait_end("ovr");
        repeat (20) @(negedge vclock);
        chk("ovr_pulses", ovr_cnt - ov0, 1);
        chk("ovr_no_restart", wr_cnt - base_cnt, 1024);
        chk("latched_idx1", cap[1], 257);
        chk("latched_idx502", cap[502], 386);
        chk("latched_idx1021", cap[1021], 257);

        // Reset mid-stream aborts, then a clean frame follows
        start_frame(16'h0000, 16'h4000, 9'd511);
        wait_idx(200);
        reset = 1'b0;
        @(negedge vclock);
        chk("abort_we", int'(wave_we), 0);
        chk("abort_prof", int'(wave_prof), 0);
        chk("abort_index", int'(wave_index), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_overrun", int'(overrun), 0);
        repeat (2) @(negedge vclock);
        reset = 1'b1;
        repeat (20) @(negedge vclock);
        chk("abort_write_count", wr_cnt - base_cnt, 201);
        start_frame(16'h0000, 16'h4000, 9'd128);
        wait_end("recover");
        chk("recover_idx0", cap[0], 382);
        chk("recover_idx3", cap[3], 511);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
